vdc_shared_scheduler: RTL and testbench
=======================================

VDC_SHARED_SCHEDULER -- requirements
Module: vdc_shared_scheduler

Interface
REQ-001 Parameter BASE, default 2, is the radix of the Van der Corput sequence; the legal range is BASE >= 2.
REQ-002 Parameter SCALE, default 10, sets the output scale to BASE^SCALE; BASE^SCALE SHALL be below 2^32.
REQ-003 Parameter NREQ, default 4, is the number of requesters; the legal range is 2..8.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request, held high until grant.
REQ-007 req_reseed  in  NREQ  qualifies req_valid: 1 = reseed op, 0 = pop op.
REQ-008 seed  in  32  shared seed value, sampled only on a granted reseed.
REQ-009 grant  out  NREQ  one-hot, one-cycle pulse acknowledging the accepted request.
REQ-010 resp_valid  out  1  pop result available.
REQ-011 resp_ready  in  1  consumer accepts the result when both resp_valid and resp_ready are high.
REQ-012 resp_id  out  clog2(NREQ)  index of the requester that owns resp_data.
REQ-013 resp_data  out  32  vdc(k) scaled by BASE^SCALE.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL keep one 32-bit index k[i] per requester and time-share a single iterative digit-reversal engine between requesters.
REQ-016 The state machine SHALL have three states:
- IDLE: arbitrate.
- CALC: one digit per cycle.
- RESP: hold the result.
REQ-017 In IDLE, when any req_valid is high, the block SHALL select requester i round-robin: search starts at last_grant+1 mod NREQ, and last_grant updates to i.
REQ-018 Reseed of i:
- k[i] <= seed.
- grant[i] pulses in the next cycle.
- The state stays IDLE; no response is produced.
REQ-019 Pop of i:
- k[i] <= k[i]+1, mod 2^32.
- Engine loads kw = k[i]+1, acc = 0, factor = BASE^SCALE.
- State goes to CALC; grant[i] pulses in the first CALC cycle.
REQ-020 Each CALC cycle SHALL apply:
- factor <= factor/BASE.
- acc <= acc + (kw mod BASE)*(factor/BASE).
- kw <= kw/BASE.
REQ-021 CALC SHALL exit to RESP in the cycle where the next kw is 0 or the next factor/BASE is 0.
- CALC length equals the digit count of kw, capped at SCALE.
- kw = 0 takes exactly 1 cycle and yields 0.
REQ-022 In RESP, the block SHALL drive resp_valid = 1 with resp_data = acc and resp_id = i, all held stable until resp_ready.
- The handshake cycle returns the state to IDLE; resp_valid is 0 the following cycle.
REQ-023 Arbitration SHALL NOT occur in CALC or RESP; requests wait.
- A requester that keeps req_valid high in its grant cycle is treated as issuing a new request.
REQ-024 k[i] at 0xFFFFFFFF SHALL wrap to 0 on pop, and resp_data SHALL be 0.
REQ-025 Base-2 latency for k = 1: request seen in IDLE at cycle T, grant at T+1, resp_valid at T+2.

Reset
REQ-026 When rst is high at a clock edge, the block SHALL set:
- State to IDLE, all k[i] to 0, last_grant to NREQ-1.
- grant, resp_valid, resp_id, resp_data and busy all to 0.
REQ-027 A reset in CALC or RESP SHALL discard the in-flight result; no response is produced for it.

Verification
REQ-028 After reset, requester 0 pops 3 times with resp_ready = 1 (BASE = 2, SCALE = 10) -> resp_data 512, 256, 768, resp_id = 0, and the REQ-025 timing holds.
REQ-029 Reseed requester 1 with seed = 5, then pop requester 1 -> 384; a following pop of requester 0 -> 128, since its index is unaffected.
REQ-030 All 4 req_valid rise together after reset -> grants in order 0, 1, 2, 3, each resp_data = 512, with no grant while busy.
REQ-031 Hold resp_ready low for 5 cycles during RESP -> resp_valid, resp_data and resp_id stay stable; a pending req_valid gets no grant until the handshake.
REQ-032 Reseed with 0xFFFFFFFF, then pop -> resp_data 0 after one CALC cycle; the next pop -> 512.
REQ-033 Assert rst during CALC -> all outputs read 0 in the next cycle, and no response appears for the in-flight pop; the first pop after release -> 512.

Source files
------------

// File: rtl/vdc_shared_scheduler.sv
// vdc_shared_scheduler
//   Keeps a 32-bit Van der Corput index per requester and shares one
//   digit-reversal engine between them. Pop ops return vdc(k+1) scaled by
//   BASE^SCALE; reseed ops load the shared seed into the requester's index.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid      per-requester request, held until granted
//   req_reseed     per-requester op select (1 = reseed, 0 = pop)
//   seed           seed value captured on a granted reseed
//   grant          one-hot, one-cycle acknowledge of the accepted request
//   resp_valid     pop result available; resp_ready completes the handshake
//   resp_id        owner of resp_data
//   resp_data      scaled digit-reversed value
//   busy           high whenever the scheduler is not idle
module vdc_shared_scheduler #(
  parameter int unsigned BASE  = 2,
  parameter int unsigned SCALE = 10,
  parameter int unsigned NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_reseed,
  input  logic [31:0]              seed,
  output logic [NREQ-1:0]          grant,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [31:0]              resp_data,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  function automatic logic [31:0] pow_f();
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < SCALE; i++) r = r * 64'(BASE);
    return r[31:0];
  endfunction

  localparam logic [31:0] FACTOR0 = pow_f();

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      k_q [NREQ];
  logic [31:0]      k_d [NREQ];
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [31:0]      kw_q, kw_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      factor_q, factor_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             found;
  logic [IDW-1:0]   pick;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    last_d   = last_q;
    owner_d  = owner_q;
    kw_d     = kw_q;
    acc_d    = acc_q;
    factor_d = factor_q;
    grant_d  = '0;
    found    = 1'b0;
    pick     = '0;

    // Round-robin search starting just after the last granted requester.
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned cand;
      cand = (32'(last_q) + 32'd1 + off) % NREQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          last_d        = pick;
          owner_d       = pick;
          grant_d[pick] = 1'b1;
          if (req_reseed[pick]) begin
            k_d[pick] = seed;
          end else begin
            k_d[pick] = k_q[pick] + 32'd1;
            kw_d      = k_q[pick] + 32'd1;
            acc_d     = '0;
            factor_d  = FACTOR0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        factor_d = factor_q / BASE;
        acc_d    = acc_q + (kw_q % BASE) * factor_d;
        kw_d     = kw_q / BASE;
        // Stop once digits run out or the scale is exhausted.
        if (kw_d == '0 || (factor_d / BASE) == '0) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int unsigned j = 0; j < NREQ; j++) k_q[j] <= '0;
      last_q   <= IDW'(NREQ - 1);
      owner_q  <= '0;
      kw_q     <= '0;
      acc_q    <= '0;
      factor_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      kw_q     <= kw_d;
      acc_q    <= acc_d;
      factor_q <= factor_d;
      grant_q  <= grant_d;
    end
  end

  assign grant      = grant_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = (state_q == RESP) ? acc_q : '0;
  assign resp_id    = (state_q == RESP) ? owner_q : '0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vdc_shared_scheduler.sv
module tb_vdc_shared_scheduler;

  localparam int unsigned BASE  = 2;
  localparam int unsigned SCALE = 10;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_reseed;
  logic [31:0]     seed;
  logic [NREQ-1:0] grant;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_data;
  logic            busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: per-requester index, last grant, and pending seeds.
  logic [31:0] mk [NREQ];
  int unsigned mlast;
  logic [31:0] pseed [NREQ];

  vdc_shared_scheduler #(.BASE(BASE), .SCALE(SCALE), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_reseed (req_reseed),
    .seed       (seed),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned ipow(input int unsigned e);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * BASE;
    return r;
  endfunction

  // Radical inverse of k: digit j (LSD first) weighs BASE^(SCALE-1-j);
  // digits past SCALE are dropped. Engine time = digit count, min 1, max SCALE.
  function automatic logic [31:0] exp_vdc(input logic [31:0] k, output int unsigned ncyc);
    longint unsigned n = k;
    longint unsigned r = 0;
    int unsigned nd = 0;
    while (n != 0) begin
      if (nd < SCALE) r += (n % BASE) * ipow(SCALE - 1 - nd);
      n = n / BASE;
      nd++;
    end
    ncyc = (nd == 0) ? 1 : ((nd > SCALE) ? SCALE : nd);
    return 32'(r);
  endfunction

  function automatic int unsigned rr_pick();
    for (int unsigned off = 1; off <= NREQ; off++) begin
      int unsigned c;
      c = (mlast + off) % NREQ;
      if (req_valid[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [31:0] onehot(input int unsigned i);
    return 32'd1 << i;
  endfunction

  task automatic model_reset();
    for (int unsigned j = 0; j < NREQ; j++) mk[j] = '0;
    mlast = NREQ - 1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp_id"}, 32'(resp_id), 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_reseed = '0;
    resp_ready = 1'b0;
    seed = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic post(input int unsigned i, input bit rs, input logic [31:0] sv);
    req_valid[i]  = 1'b1;
    req_reseed[i] = rs;
    pseed[i]      = sv;
  endtask

  // Expects IDLE with the pending set already visible; serves one request.
  task automatic service_one(input int unsigned hold);
    int unsigned i, nc, cnt;
    logic [31:0] ed;
    bit got;
    i = rr_pick();
    if (req_reseed[i]) seed = pseed[i];
    else seed = $urandom();
    step();
    chk("grant", 32'(grant), onehot(i));
    mlast = i;
    req_valid[i] = 1'b0;
    if (req_reseed[i]) begin
      mk[i] = pseed[i];
      req_reseed[i] = 1'b0;
      chk("reseed_busy", 32'(busy), 0);
      chk("reseed_resp_valid", 32'(resp_valid), 0);
    end else begin
      mk[i] = mk[i] + 32'd1;
      ed = exp_vdc(mk[i], nc);
      chk("pop_busy", 32'(busy), 1);
      chk("pop_grant_resp_valid", 32'(resp_valid), 0);
      resp_ready = (hold == 0);
      got = 0;
      cnt = 0;
      while (!got && cnt < 40) begin
        step();
        cnt++;
        if (resp_valid === 1'b1) got = 1;
        else chk("calc_no_grant", 32'(grant), 0);
      end
      chk("calc_cycles", cnt, nc);
      chk("resp_data", resp_data, ed);
      chk("resp_id", 32'(resp_id), i);
      for (int unsigned h = 0; h < hold; h++) begin
        step();
        chk("hold_valid", 32'(resp_valid), 1);
        chk("hold_data", resp_data, ed);
        chk("hold_id", 32'(resp_id), i);
        chk("hold_no_grant", 32'(grant), 0);
      end
      resp_ready = 1'b1;
      step();
      chk("after_hs_valid", 32'(resp_valid), 0);
      chk("after_hs_busy", 32'(busy), 0);
      resp_ready = 1'b0;
    end
  endtask

  task automatic service_all(input int unsigned hold);
    int unsigned guard = 0;
    while (req_valid != '0 && guard < 2 * NREQ) begin
      service_one(hold);
      guard++;
    end
    chk("drain_done", 32'(req_valid), 0);
  endtask

  initial begin
    do_reset();

    // Three pops of requester 0: 512, 256, 768.
    for (int n = 0; n < 3; n++) begin
      post(0, 0, '0);
      service_one(0);
    end

    // Reseed requester 1 with 5, pop it (384), then pop requester 0 (128).
    post(1, 1, 32'd5);
    service_one(0);
    post(1, 0, '0);
    service_one(0);
    post(0, 0, '0);
    service_one(0);

    // All four requesters together after reset: grants in order 0..3.
    do_reset();
    for (int unsigned j = 0; j < NREQ; j++) post(j, 0, '0);
    service_all(0);

    // Stall the consumer with another request pending.
    post(2, 0, '0);
    post(3, 0, '0);
    service_one(5);
    service_one(0);

    // Index wrap: reseed to all-ones, pop gives 0, next pop gives 512.
    post(1, 1, 32'hFFFF_FFFF);
    service_one(0);
    post(1, 0, '0);
    service_one(0);
    post(1, 0, '0);
    service_one(0);

    // Reset in the middle of a long calculation.
    post(2, 1, 32'd1000);
    service_one(0);
    post(2, 0, '0);
    seed = '0;
    step();
    chk("midcalc_grant", 32'(grant), onehot(2));
    req_valid = '0;
    rst = 1'b1;
    step();
    check_all_zero("midcalc_reset");
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 12; n++) begin
      step();
      chk("no_stale_resp", 32'(resp_valid), 0);
    end
    post(0, 0, '0);
    service_one(0);

    // Randomized traffic against the reference model.
    for (int iter = 0; iter < 40; iter++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          logic [31:0] sv;
          case ($urandom_range(0, 3))
            0: sv = 32'hFFFF_FFFF;
            1: sv = 32'($urandom_range(0, 20));
            default: sv = $urandom();
          endcase
          post(j, ($urandom_range(0, 3) == 0), sv);
        end
      end
      if (req_valid == '0) post($urandom_range(0, NREQ - 1), 0, '0);
      service_all($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
